// File: rtl/a2c_cmd_sequencer_if.sv
// Receiver command handshake plus framebuffer write port, as seen by the sequencer (master) and its environment (slave).
interface a2c_cmd_sequencer_if #(
  parameter int ADDR_W  = 12,
  parameter int COLOR_W = 24
);
  localparam int CMD_W = 4 + ADDR_W + COLOR_W;

  logic               cmd_valid;
  logic [CMD_W-1:0]   cmd_data;
  logic               cmd_done;
  logic               fb_we;
  logic [ADDR_W:0]    fb_addr;
  logic [COLOR_W-1:0] fb_wdata;
  logic               fb_ready;

  modport master (
    input  cmd_valid, cmd_data, fb_ready,
    output cmd_done, fb_we, fb_addr, fb_wdata
  );

  modport slave (
    output cmd_valid, cmd_data, fb_ready,
    input  cmd_done, fb_we, fb_addr, fb_wdata
  );
endinterface

// File: rtl/a2c_cmd_sequencer.sv
// Decodes A2C command words into back-bank pixel writes, bank fills, vsync bank swaps and brightness updates.
// First write 2 cycles after cmd_valid; fb_ready low stalls with fb_* held; cmd_done one cycle after the last write.
module a2c_cmd_sequencer #(
  parameter int ADDR_W  = 12,
  parameter int COLOR_W = 24
) (
  input  logic                       clk50,
  input  logic                       rst_n,
  a2c_cmd_sequencer_if.master        bus,
  input  logic                       frame_start,
  output logic                       front_bank,
  output logic [7:0]                 brightness,
  output logic [15:0]                cmd_count,
  output logic [7:0]                 err_count,
  output logic                       busy
);
  localparam int CMD_W = 4 + ADDR_W + COLOR_W;
  localparam logic [3:0] OP_WRITE  = 4'h1;
  localparam logic [3:0] OP_FILL   = 4'h2;
  localparam logic [3:0] OP_SWAP   = 4'h3;
  localparam logic [3:0] OP_BRIGHT = 4'h4;
  localparam logic [ADDR_W:0] FILL_LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] FILL_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_WRITE, S_FILL, S_SWAP_WAIT, S_ACK, S_WAIT_LOW
  } state_t;

  state_t             state, state_nxt;
  logic [CMD_W-1:0]   cmd_q;
  logic               back_bank;
  logic [ADDR_W:0]    fill_cnt;
  logic [3:0]         opcode;
  logic [ADDR_W-1:0]  pix_addr;
  logic [COLOR_W-1:0] color;
  logic               op_legal;
  logic               we;
  logic               wr_acc;

  assign opcode   = cmd_q[CMD_W-1 -: 4];
  assign pix_addr = cmd_q[COLOR_W +: ADDR_W];
  assign color    = cmd_q[COLOR_W-1:0];
  assign op_legal = (opcode >= OP_WRITE) && (opcode <= OP_BRIGHT);
  assign wr_acc   = we && bus.fb_ready;

  assign bus.fb_we    = we;
  assign bus.fb_addr  = we ? {back_bank, (state == S_FILL) ? fill_cnt[ADDR_W-1:0] : pix_addr} : '0;
  assign bus.fb_wdata = we ? color : '0;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    we           = 1'b0;
    bus.cmd_done = 1'b0;
    busy         = (state != S_IDLE);
    case (state)
      S_IDLE:   if (bus.cmd_valid) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_WRITE: state_nxt = S_WRITE;
          OP_FILL:  state_nxt = S_FILL;
          OP_SWAP:  state_nxt = S_SWAP_WAIT;
          default:  state_nxt = S_ACK;
        endcase
      end
      S_WRITE: begin
        we = 1'b1;
        if (bus.fb_ready) state_nxt = S_ACK;
      end
      S_FILL: begin
        we = 1'b1;
        if (bus.fb_ready && (fill_cnt == FILL_LAST)) state_nxt = S_ACK;
      end
      S_SWAP_WAIT: if (frame_start) state_nxt = S_ACK;
      S_ACK: begin
        bus.cmd_done = 1'b1;
        state_nxt    = S_WAIT_LOW;
      end
      // Holding here until valid drops keeps a slow receiver from replaying the same word.
      S_WAIT_LOW: if (!bus.cmd_valid) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q      <= '0;
      back_bank  <= 1'b0;
      fill_cnt   <= '0;
      front_bank <= 1'b0;
      brightness <= 8'hFF;
      cmd_count  <= '0;
      err_count  <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.cmd_valid) cmd_q <= bus.cmd_data;
        S_DECODE: begin
          cmd_count <= cmd_count + 16'd1;
          back_bank <= ~front_bank;
          fill_cnt  <= '0;
          if (opcode == OP_BRIGHT) brightness <= color[7:0];
          if (!op_legal && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
        end
        S_FILL:      if (wr_acc) fill_cnt <= fill_cnt + FILL_ONE;
        S_SWAP_WAIT: if (frame_start) front_bank <= ~front_bank;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_a2c_cmd_sequencer.sv
// Randomized self-checking bench for a2c_cmd_sequencer against a command-level reference model.
module tb_a2c_cmd_sequencer;
  localparam int ADDR_W  = 12;
  localparam int COLOR_W = 24;

  logic        clk50 = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        front_bank;
  logic [7:0]  brightness;
  logic [15:0] cmd_count;
  logic [7:0]  err_count;
  logic        busy;

  a2c_cmd_sequencer_if #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) bus ();

  a2c_cmd_sequencer #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) dut (
    .clk50      (clk50),
    .rst_n      (rst_n),
    .bus        (bus),
    .frame_start(frame_start),
    .front_bank (front_bank),
    .brightness (brightness),
    .cmd_count  (cmd_count),
    .err_count  (err_count),
    .busy       (busy)
  );

  initial forever #10 clk50 = ~clk50;

  int n_cmp = 0;
  int n_err = 0;

  // Observed traffic, sampled on the falling edge
  logic [12:0] wr_addr_q[$];
  logic [23:0] wr_data_q[$];
  int          done_cnt   = 0;
  int          we_cycles  = 0;
  int          stab_err   = 0;
  logic        prev_stall = 1'b0;
  logic [12:0] prev_addr;
  logic [23:0] prev_data;

  initial forever begin
    @(negedge clk50);
    if (rst_n) begin
      if (prev_stall && (bus.fb_we !== 1'b1 || bus.fb_addr !== prev_addr || bus.fb_wdata !== prev_data))
        stab_err++;
      if (bus.fb_we) we_cycles++;
      if (bus.fb_we && bus.fb_ready) begin
        wr_addr_q.push_back(bus.fb_addr);
        wr_data_q.push_back(bus.fb_wdata);
      end
      if (bus.cmd_done) done_cnt++;
      prev_stall = bus.fb_we && !bus.fb_ready;
      prev_addr  = bus.fb_addr;
      prev_data  = bus.fb_wdata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  bit rnd_ready = 1'b0;
  initial begin
    bus.fb_ready = 1'b1;
    forever begin
      @(posedge clk50); #2;
      bus.fb_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #1_800_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: architectural state and the write stream each command must produce
  logic        m_front;
  logic [7:0]  m_bright;
  logic [15:0] m_cmd;
  logic [7:0]  m_err;
  logic [12:0] e_addr_q[$];
  logic [23:0] e_data_q[$];

  task automatic model_reset();
    m_front = 1'b0; m_bright = 8'hFF; m_cmd = 16'd0; m_err = 8'd0;
  endtask

  task automatic model_cmd(input logic [39:0] w);
    logic [3:0] op;
    op = w[39:36];
    m_cmd = m_cmd + 16'd1;
    if (op == 4'h1) begin
      e_addr_q.push_back({~m_front, w[35:24]});
      e_data_q.push_back(w[23:0]);
    end else if (op == 4'h2) begin
      for (int i = 0; i < 4096; i++) begin
        e_addr_q.push_back({~m_front, 12'(i)});
        e_data_q.push_back(w[23:0]);
      end
    end else if (op == 4'h3) begin
      m_front = ~m_front;
    end else if (op == 4'h4) begin
      m_bright = w[7:0];
    end else if (m_err != 8'd255) begin
      m_err = m_err + 8'd1;
    end
  endtask

  task automatic clear_queues();
    wr_addr_q.delete(); wr_data_q.delete();
    e_addr_q.delete();  e_data_q.delete();
  endtask

  function automatic int q_diff();
    int d;
    d = (wr_addr_q.size() > e_addr_q.size()) ? wr_addr_q.size() - e_addr_q.size()
                                              : e_addr_q.size() - wr_addr_q.size();
    for (int i = 0; i < e_addr_q.size() && i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] !== e_addr_q[i] || wr_data_q[i] !== e_data_q[i]) d++;
    return d;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_data = '0; frame_start = 1'b0;
    repeat (3) @(posedge clk50);
    #2 rst_n = 1'b1;
    model_reset();
    clear_queues();
    @(posedge clk50); #2;
  endtask

  // Presents one word, pulses frame_start swap_dly cycles in (if nonzero), waits for cmd_done,
  // keeps cmd_valid high for hold more cycles, then lets the sequencer return to idle.
  task automatic run_cmd(input logic [39:0] w, input int hold, input int swap_dly, output bit ok);
    int d0, cyc;
    d0 = done_cnt; cyc = 0; ok = 1'b1;
    @(posedge clk50); #2;
    bus.cmd_valid = 1'b1; bus.cmd_data = w;
    while (done_cnt == d0 && cyc < 12000) begin
      @(posedge clk50); #2;
      cyc++;
      frame_start = (swap_dly > 0 && cyc == swap_dly);
    end
    frame_start = 1'b0;
    if (done_cnt == d0) ok = 1'b0;
    repeat (hold) begin @(posedge clk50); #2; end
    bus.cmd_valid = 1'b0;
    repeat (2) begin @(posedge clk50); #2; end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk50);
    n_cmp++; if (bus.fb_we !== 1'b0)     begin n_err++; $display("FAIL reset_fb_we: got %b want 0", bus.fb_we); end
    n_cmp++; if (bus.cmd_done !== 1'b0)  begin n_err++; $display("FAIL reset_cmd_done: got %b want 0", bus.cmd_done); end
    n_cmp++; if (bus.fb_addr !== 13'h0)  begin n_err++; $display("FAIL reset_fb_addr: got %h want 0", bus.fb_addr); end
    n_cmp++; if (bus.fb_wdata !== 24'h0) begin n_err++; $display("FAIL reset_fb_wdata: got %h want 0", bus.fb_wdata); end
    n_cmp++; if (front_bank !== 1'b0)    begin n_err++; $display("FAIL reset_front_bank: got %b want 0", front_bank); end
    n_cmp++; if (brightness !== 8'hFF)   begin n_err++; $display("FAIL reset_brightness: got %h want ff", brightness); end
    n_cmp++; if (cmd_count !== 16'h0)    begin n_err++; $display("FAIL reset_cmd_count: got %h want 0", cmd_count); end
    n_cmp++; if (err_count !== 8'h0)     begin n_err++; $display("FAIL reset_err_count: got %h want 0", err_count); end
    n_cmp++; if (busy !== 1'b0)          begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_write_pixel();
    logic [39:0] w;
    int n, d0;
    w = 40'h1_123_FF8000; rnd_ready = 1'b0; d0 = done_cnt; n = 0;
    @(posedge clk50); #2;
    bus.cmd_valid = 1'b1; bus.cmd_data = w;
    do begin @(negedge clk50); n++; end while (bus.fb_we !== 1'b1 && n < 10);
    n_cmp++; if (n !== 3) begin n_err++; $display("FAIL wp_latency: fb_we on falling edge %0d after valid, want 3", n); end
    n_cmp++; if (bus.fb_addr !== 13'h1123) begin n_err++; $display("FAIL wp_addr: got %h want 1123", bus.fb_addr); end
    n_cmp++; if (bus.fb_wdata !== 24'hFF8000) begin n_err++; $display("FAIL wp_data: got %h want ff8000", bus.fb_wdata); end
    @(negedge clk50);
    n_cmp++; if (bus.cmd_done !== 1'b1 || bus.fb_we !== 1'b0)
      begin n_err++; $display("FAIL wp_done_timing: cmd_done=%b fb_we=%b want 1/0", bus.cmd_done, bus.fb_we); end
    @(posedge clk50); #2; bus.cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk50); #2; end
    model_cmd(w);
    n_cmp++; if (q_diff() !== 0) begin n_err++; $display("FAIL wp_writes: %0d differences, %0d writes seen want 1", q_diff(), wr_addr_q.size()); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL wp_done_count: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (cmd_count !== m_cmd) begin n_err++; $display("FAIL wp_cmd_count: got %0d want %0d", cmd_count, m_cmd); end
  endtask

  task automatic test_fill();
    logic [39:0] w;
    bit ok;
    int d0;
    w = 40'h2_000_0000FF; clear_queues(); rnd_ready = 1'b1; d0 = done_cnt; stab_err = 0;
    run_cmd(w, 0, 0, ok);
    rnd_ready = 1'b0;
    model_cmd(w);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL fill_timeout: got no cmd_done want one"); end
    n_cmp++; if (wr_addr_q.size() !== 4096) begin n_err++; $display("FAIL fill_count: got %0d writes want 4096", wr_addr_q.size()); end
    n_cmp++; if (q_diff() !== 0) begin n_err++; $display("FAIL fill_addrs: %0d differing writes want 0", q_diff()); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL fill_done: got %0d pulses want 1", done_cnt - d0); end
    n_cmp++; if (stab_err !== 0) begin n_err++; $display("FAIL fill_stall_hold: got %0d unstable stalls want 0", stab_err); end
  endtask

  task automatic test_swap();
    logic [39:0] w;
    bit ok;
    int d0, we0;
    w = 40'h3_000_000000; rnd_ready = 1'b0; d0 = done_cnt; we0 = we_cycles;
    @(posedge clk50); #2;
    bus.cmd_valid = 1'b1; bus.cmd_data = w;
    repeat (100) begin @(posedge clk50); #2; end
    frame_start = 1'b1;
    @(negedge clk50);
    n_cmp++; if (front_bank !== 1'b0 || bus.cmd_done !== 1'b0)
      begin n_err++; $display("FAIL swap_before: front=%b done=%b want 0/0", front_bank, bus.cmd_done); end
    @(posedge clk50); #2; frame_start = 1'b0;
    @(negedge clk50);
    n_cmp++; if (front_bank !== 1'b1 || bus.cmd_done !== 1'b1)
      begin n_err++; $display("FAIL swap_after: front=%b done=%b want 1/1", front_bank, bus.cmd_done); end
    @(posedge clk50); #2; bus.cmd_valid = 1'b0;
    repeat (2) begin @(posedge clk50); #2; end
    model_cmd(w);
    n_cmp++; if (we_cycles !== we0) begin n_err++; $display("FAIL swap_no_write: got %0d fb_we cycles want 0", we_cycles - we0); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL swap_done: got %0d pulses want 1", done_cnt - d0); end
    clear_queues();
    w = 40'h1_055_00ABCD;
    run_cmd(w, 0, 0, ok);
    model_cmd(w);
    n_cmp++; if (!ok || q_diff() !== 0) begin n_err++; $display("FAIL swap_next_write: ok=%b diffs=%0d want 1/0", ok, q_diff()); end
    n_cmp++; if (wr_addr_q[0][12] !== 1'b0) begin n_err++; $display("FAIL swap_next_bank: got %b want 0", wr_addr_q[0][12]); end
  endtask

  task automatic test_illegal_bright();
    bit ok1, ok2;
    do_reset();
    run_cmd(40'hF_000_000000, 0, 0, ok1); model_cmd(40'hF_000_000000);
    run_cmd(40'h4_000_000040, 0, 0, ok2); model_cmd(40'h4_000_000040);
    n_cmp++; if (!(ok1 && ok2)) begin n_err++; $display("FAIL ib_done: got %b%b want 11", ok1, ok2); end
    n_cmp++; if (err_count !== 8'd1) begin n_err++; $display("FAIL ib_err_count: got %0d want 1", err_count); end
    n_cmp++; if (cmd_count !== 16'd2) begin n_err++; $display("FAIL ib_cmd_count: got %0d want 2", cmd_count); end
    n_cmp++; if (brightness !== 8'h40) begin n_err++; $display("FAIL ib_brightness: got %h want 40", brightness); end
    n_cmp++; if (wr_addr_q.size() !== 0) begin n_err++; $display("FAIL ib_no_write: got %0d writes want 0", wr_addr_q.size()); end
  endtask

  task automatic test_hold_valid();
    logic [39:0] w;
    bit ok;
    int d0;
    w = 40'h1_7FE_123456; clear_queues(); d0 = done_cnt;
    run_cmd(w, 3, 0, ok);
    repeat (4) begin @(posedge clk50); #2; end
    model_cmd(w);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL hold_done: got %0d pulses want 1", done_cnt - d0); end
    n_cmp++; if (cmd_count !== m_cmd) begin n_err++; $display("FAIL hold_cmd_count: got %0d want %0d", cmd_count, m_cmd); end
    n_cmp++; if (q_diff() !== 0) begin n_err++; $display("FAIL hold_writes: %0d differences, %0d writes want 1", q_diff(), wr_addr_q.size()); end
  endtask

  task automatic test_err_saturate();
    logic [39:0] w;
    bit ok;
    int miss;
    miss = 0;
    for (int k = 0; k < 258; k++) begin
      w = {4'(($urandom_range(5, 15))), 36'($urandom)};
      run_cmd(w, 0, 0, ok);
      model_cmd(w);
      if (!ok) miss++;
      if (k == 254) begin
        n_cmp++; if (err_count !== m_err) begin n_err++; $display("FAIL sat_mid: got %0d want %0d", err_count, m_err); end
      end
    end
    n_cmp++; if (miss !== 0) begin n_err++; $display("FAIL sat_done: got %0d missing acks want 0", miss); end
    n_cmp++; if (err_count !== 8'd255) begin n_err++; $display("FAIL sat_err_count: got %0d want 255", err_count); end
    n_cmp++; if (cmd_count !== m_cmd) begin n_err++; $display("FAIL sat_cmd_count: got %0d want %0d", cmd_count, m_cmd); end
  endtask

  task automatic test_random();
    logic [39:0] w;
    logic [3:0]  op;
    int sel;
    bit ok;
    clear_queues(); rnd_ready = 1'b1; stab_err = 0;
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      op = 4'h1;
      else if (sel < 6) op = 4'h3;
      else if (sel < 8) op = 4'h4;
      else              op = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(5, 15));
      w = {op, 36'($urandom)};
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk50); #2; frame_start = 1'b1;
        @(posedge clk50); #2; frame_start = 1'b0;
      end
      run_cmd(w, $urandom_range(0, 3), (op == 4'h3) ? $urandom_range(2, 15) : 0, ok);
      model_cmd(w);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rnd_done[%0d]: op %h got no ack", k, op); end
      n_cmp++; if (front_bank !== m_front) begin n_err++; $display("FAIL rnd_front[%0d]: got %b want %b", k, front_bank, m_front); end
      n_cmp++; if (brightness !== m_bright) begin n_err++; $display("FAIL rnd_bright[%0d]: got %h want %h", k, brightness, m_bright); end
      n_cmp++; if (cmd_count !== m_cmd) begin n_err++; $display("FAIL rnd_cmd_count[%0d]: got %0d want %0d", k, cmd_count, m_cmd); end
      n_cmp++; if (err_count !== m_err) begin n_err++; $display("FAIL rnd_err_count[%0d]: got %0d want %0d", k, err_count, m_err); end
      n_cmp++; if (q_diff() !== 0) begin n_err++; $display("FAIL rnd_writes[%0d]: %0d differences", k, q_diff()); end
    end
    rnd_ready = 1'b0;
    n_cmp++; if (stab_err !== 0) begin n_err++; $display("FAIL rnd_stall_hold: got %0d unstable stalls want 0", stab_err); end
  endtask

  task automatic test_reset_mid_fill();
    int n, d0;
    rnd_ready = 1'b0; n = 0;
    @(posedge clk50); #2;
    bus.cmd_valid = 1'b1; bus.cmd_data = 40'h2_000_00FF00;
    do begin @(negedge clk50); n++; end while (!(bus.fb_we === 1'b1 && bus.fb_addr[11:0] === 12'd1000) && n < 5000);
    n_cmp++; if (n >= 5000) begin n_err++; $display("FAIL rst_fill_reach: fill never reached address 1000"); end
    rst_n = 1'b0; bus.cmd_valid = 1'b0;
    #1;
    n_cmp++; if (bus.fb_we !== 1'b0) begin n_err++; $display("FAIL rst_fill_we: got %b want 0", bus.fb_we); end
    n_cmp++; if (busy !== 1'b0 || bus.cmd_done !== 1'b0 || bus.fb_addr !== 13'h0)
      begin n_err++; $display("FAIL rst_fill_outs: busy=%b done=%b addr=%h want 0/0/0", busy, bus.cmd_done, bus.fb_addr); end
    n_cmp++; if (front_bank !== 1'b0 || brightness !== 8'hFF || cmd_count !== 16'h0 || err_count !== 8'h0)
      begin n_err++; $display("FAIL rst_fill_regs: front=%b bright=%h cmd=%h err=%h", front_bank, brightness, cmd_count, err_count); end
    clear_queues(); d0 = done_cnt;
    repeat (2) @(posedge clk50);
    #2 rst_n = 1'b1;
    repeat (10) begin @(posedge clk50); #2; end
    n_cmp++; if (done_cnt !== d0) begin n_err++; $display("FAIL rst_fill_no_done: got %0d pulses want 0", done_cnt - d0); end
    n_cmp++; if (wr_addr_q.size() !== 0) begin n_err++; $display("FAIL rst_fill_no_write: got %0d writes want 0", wr_addr_q.size()); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    model_reset();
    test_reset();
    test_write_pixel();
    test_fill();
    test_swap();
    test_illegal_bright();
    test_hold_valid();
    test_err_saturate();
    test_random();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
